// File: rtl/hub75_row_capture_if.sv
// hub75_row_capture_if: panel pin bundle (driver side = master) plus captured-row results.
interface hub75_row_capture_if #(
  parameter int COLS   = 32,
  parameter int PLANES = 4,
  parameter int ADDR_W = 4
);
  logic [2:0]               rgb_top;
  logic [2:0]               rgb_bot;
  logic [ADDR_W-1:0]        addr_in;
  logic                     oe_in;
  logic                     le_in;
  logic                     row_valid;
  logic [ADDR_W-1:0]        row_addr;
  logic [COLS*3*PLANES-1:0] row_top;
  logic [COLS*3*PLANES-1:0] row_bot;
  logic                     err_len;
  logic                     err_addr;
  logic                     err_oe;
  logic [15:0]              row_cnt;
  logic [15:0]              err_cnt;
  modport master (
    output rgb_top, rgb_bot, addr_in, oe_in, le_in,
    input  row_valid, row_addr, row_top, row_bot, err_len, err_addr, err_oe, row_cnt, err_cnt
  );
  modport slave (
    input  rgb_top, rgb_bot, addr_in, oe_in, le_in,
    output row_valid, row_addr, row_top, row_bot, err_len, err_addr, err_oe, row_cnt, err_cnt
  );
endinterface

// File: rtl/hub75_row_capture.sv
// hub75_row_capture: HUB75 receiver assembling PLANES latched bit-planes into a pixel row.
// Optional HUB75_ROW_CAPTURE_STATS_EN builds saturating row/fault counters.
module hub75_row_capture #(
  parameter int COLS   = 32,
  parameter int PLANES = 4,
  parameter int ADDR_W = 4
) (
  input logic bclk,
  input logic n_reset,
  hub75_row_capture_if.slave bus
);
  localparam int W  = COLS * 3 * PLANES;
  localparam int BW = $clog2(COLS + 2);
  localparam int PW = PLANES > 1 ? $clog2(PLANES) : 1;
  localparam logic [BW-1:0] cnt_full = BW'(COLS);
  localparam logic [BW-1:0] cnt_sat  = BW'(COLS + 1);
  localparam logic [PW-1:0] last     = PW'(PLANES - 1);

  logic [COLS-1:0]   sr [6];
  logic [COLS-1:0]   store [PLANES][6];
  logic [BW-1:0]     bit_cnt;
  logic [PW-1:0]     plane_idx;
  logic [ADDR_W-1:0] cur_addr;
  logic              le_q;
  logic              latch;
  logic              mis;
  logic [PW-1:0]     p_eff;
  logic [5:0]        bits;
  logic [W-1:0]      next_top;
  logic [W-1:0]      next_bot;

  assign bits  = {bus.rgb_bot, bus.rgb_top};
  assign latch = bus.le_in & ~le_q;
  assign mis   = plane_idx != '0 && bus.addr_in != cur_addr;
  assign p_eff = mis ? '0 : plane_idx;

  // the final plane is taken straight from the shift regs so the row is out 1 cycle after its latch
  always_comb begin
    next_top = '0;
    next_bot = '0;
    for (int p = 0; p < PLANES; p++)
      for (int c = 0; c < COLS; c++)
        for (int ch = 0; ch < 3; ch++) begin
          next_top[(c*3+ch)*PLANES+p] = (p == PLANES - 1) ? sr[ch][c]   : store[p][ch][c];
          next_bot[(c*3+ch)*PLANES+p] = (p == PLANES - 1) ? sr[ch+3][c] : store[p][ch+3][c];
        end
  end

  always_ff @(posedge bclk) begin
    if (!n_reset) begin
      for (int ch = 0; ch < 6; ch++) sr[ch] <= '0;
      for (int p = 0; p < PLANES; p++)
        for (int ch = 0; ch < 6; ch++) store[p][ch] <= '0;
      bit_cnt       <= '0;
      plane_idx     <= '0;
      cur_addr      <= '0;
      le_q          <= 1'b0;
      bus.row_valid <= 1'b0;
      bus.row_addr  <= '0;
      bus.row_top   <= '0;
      bus.row_bot   <= '0;
      bus.err_len   <= 1'b0;
      bus.err_addr  <= 1'b0;
      bus.err_oe    <= 1'b0;
    end else begin
      le_q          <= bus.le_in;
      bus.row_valid <= 1'b0;
      bus.err_len   <= 1'b0;
      bus.err_addr  <= 1'b0;
      bus.err_oe    <= 1'b0;
      if (!bus.le_in) begin
        for (int ch = 0; ch < 6; ch++) sr[ch] <= {sr[ch][COLS-2:0], bits[ch]};
        if (bit_cnt != cnt_sat) bit_cnt <= bit_cnt + 1'b1;
      end else begin
        bit_cnt <= '0;
        if (latch) begin
          bus.err_len  <= bit_cnt != cnt_full;
          bus.err_oe   <= ~bus.oe_in;
          bus.err_addr <= mis;
          if (p_eff == '0) cur_addr <= bus.addr_in;
          for (int ch = 0; ch < 6; ch++) store[p_eff][ch] <= sr[ch];
          if (p_eff == last) begin
            bus.row_valid <= 1'b1;
            bus.row_addr  <= bus.addr_in;
            bus.row_top   <= next_top;
            bus.row_bot   <= next_bot;
            plane_idx     <= '0;
          end else begin
            plane_idx <= p_eff + 1'b1;
          end
        end
      end
    end
  end

`ifdef HUB75_ROW_CAPTURE_STATS_EN
  always_ff @(posedge bclk) begin
    if (!n_reset) begin
      bus.row_cnt <= '0;
      bus.err_cnt <= '0;
    end else begin
      if (bus.row_valid && bus.row_cnt != 16'hFFFF) bus.row_cnt <= bus.row_cnt + 16'd1;
      if ((bus.err_len | bus.err_addr | bus.err_oe) && bus.err_cnt != 16'hFFFF)
        bus.err_cnt <= bus.err_cnt + 16'd1;
    end
  end
`else
  assign bus.row_cnt = '0;
  assign bus.err_cnt = '0;
`endif
endmodule

// File: tb/tb_hub75_row_capture.sv
// tb_hub75_row_capture: randomized + directed planes checked by a queue-based scoreboard.
module tb_hub75_row_capture;
  localparam int COLS = 32, PLANES = 4, ADDR_W = 4, W = COLS * 3 * PLANES;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [W-1:0]      top;
    logic [W-1:0]      bot;
  } row_t;

  logic bclk = 1'b0;
  logic n_reset = 1'b0;
  always #5 bclk = ~bclk;

  hub75_row_capture_if #(.COLS(COLS), .PLANES(PLANES), .ADDR_W(ADDR_W)) bus ();
  hub75_row_capture #(.COLS(COLS), .PLANES(PLANES), .ADDR_W(ADDR_W)) dut (
    .bclk(bclk), .n_reset(n_reset), .bus(bus)
  );

  int total = 0, bad = 0;
  row_t exp_rows[$];
  logic [2:0] exp_errs[$];

  bit sq[6][$];
  int m_bits = 0, m_pidx = 0, m_rows = 0, m_errs = 0;
  logic [ADDR_W-1:0] m_addr = '0;
  bit [COLS-1:0] m_planes[PLANES][6];

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge bclk);
    #1;
  endtask

  task automatic model_clear();
    for (int ch = 0; ch < 6; ch++) sq[ch].delete();
    m_bits = 0; m_pidx = 0; m_rows = 0; m_errs = 0; m_addr = '0;
  endtask

  task automatic model_latch(input logic [ADDR_W-1:0] a, input logic oe);
    bit mis;
    row_t r;
    mis = m_pidx > 0 && a != m_addr;
    if (mis || m_bits != COLS || !oe) begin
      exp_errs.push_back({mis, m_bits != COLS, !oe});
      m_errs++;
    end
    if (mis || m_pidx == 0) begin
      m_pidx = 0;
      m_addr = a;
    end
    for (int ch = 0; ch < 6; ch++)
      for (int c = 0; c < COLS; c++)
        m_planes[m_pidx][ch][c] = c < sq[ch].size() ? sq[ch][c] : 1'b0;
    m_bits = 0;
    if (m_pidx == PLANES - 1) begin
      r.addr = m_addr; r.top = '0; r.bot = '0;
      for (int c = 0; c < COLS; c++)
        for (int ch = 0; ch < 3; ch++)
          for (int p = 0; p < PLANES; p++) begin
            r.top[(c*3+ch)*PLANES+p] = m_planes[p][ch][c];
            r.bot[(c*3+ch)*PLANES+p] = m_planes[p][ch+3][c];
          end
      exp_rows.push_back(r);
      m_rows++;
      m_pidx = 0;
    end else m_pidx++;
  endtask

  task automatic shift(input logic [2:0] t, input logic [2:0] b);
    bus.le_in = 1'b0; bus.oe_in = 1'b1; bus.rgb_top = t; bus.rgb_bot = b;
    for (int ch = 0; ch < 6; ch++) begin
      sq[ch].push_front(ch < 3 ? t[ch] : b[ch-3]);
      if (sq[ch].size() > COLS) void'(sq[ch].pop_back());
    end
    if (m_bits < COLS + 1) m_bits++;
    tick();
  endtask

  task automatic latch(input logic [ADDR_W-1:0] a, input logic oe, input int w);
    bus.le_in = 1'b1; bus.addr_in = a; bus.oe_in = oe;
    model_latch(a, oe);
    repeat (w) tick();
  endtask

  task automatic send_plane(input logic [ADDR_W-1:0] a, input logic oe, input int n, input int w,
                            input logic [3*COLS-1:0] t, input logic [3*COLS-1:0] b);
    for (int i = 0; i < n; i++) begin
      int col;
      logic [2:0] tv, bv;
      col = n - 1 - i;
      for (int ch = 0; ch < 3; ch++) begin
        tv[ch] = col < COLS ? t[ch*COLS+col] : 1'b0;
        bv[ch] = col < COLS ? b[ch*COLS+col] : 1'b0;
      end
      shift(tv, bv);
    end
    latch(a, oe, w);
  endtask

  task automatic do_reset();
    n_reset = 1'b0; bus.le_in = 1'b0;
    model_clear();
    repeat (2) tick();
    n_reset = 1'b1;
  endtask

  // monitor: pops the scoreboard whenever the DUT shows a row or a fault pulse
  logic prev_rst = 1'b0;
  logic [W-1:0] last_top = '0, last_bot = '0;
  initial forever begin
    @(negedge bclk);
    if (!n_reset) begin
      last_top = '0;
      last_bot = '0;
    end else if (prev_rst) begin
      if (bus.row_valid) begin
        if (exp_rows.size() == 0) check("unexpected_row", 1, 0);
        else begin
          row_t r;
          r = exp_rows.pop_front();
          check("row_addr", bus.row_addr, r.addr);
          check("row_top", bus.row_top, r.top);
          check("row_bot", bus.row_bot, r.bot);
          last_top = r.top;
          last_bot = r.bot;
        end
      end else begin
        check("hold_top", bus.row_top, last_top);
        check("hold_bot", bus.row_bot, last_bot);
      end
      if ({bus.err_addr, bus.err_len, bus.err_oe} != 3'b000) begin
        if (exp_errs.size() == 0) check("unexpected_err", {bus.err_addr, bus.err_len, bus.err_oe}, 0);
        else check("err_flags", {bus.err_addr, bus.err_len, bus.err_oe}, exp_errs.pop_front());
      end
    end
    prev_rst = n_reset;
  end

  initial begin
    logic [3*COLS-1:0] t, b;
    logic [ADDR_W-1:0] ra;
    int n;
    bus.rgb_top = '0; bus.rgb_bot = '0; bus.addr_in = '0; bus.oe_in = 1'b1; bus.le_in = 1'b0;
    repeat (2) tick();
    check("rst_valid", bus.row_valid, 0);
    check("rst_addr", bus.row_addr, 0);
    check("rst_top", bus.row_top, 0);
    check("rst_bot", bus.row_bot, 0);
    check("rst_err", {bus.err_addr, bus.err_len, bus.err_oe}, 0);
    check("rst_cnt", {bus.row_cnt, bus.err_cnt}, 0);
    do_reset();
    for (int p = 0; p < PLANES; p++) begin
      t = '0;
      t[5] = (4'hA >> p) & 1;
      send_plane(3, 1'b1, COLS, 1, t, '0);
    end
    check("dir_addr", bus.row_addr, 3);
    check("dir_pixel", bus.row_top[15*4+:4], 4'hA);
    for (int p = 0; p < PLANES; p++)
      send_plane(5, 1'b1, p == 1 ? COLS - 1 : COLS, 1, {$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom});
    send_plane(2, 1'b1, COLS, 1, {$urandom, $urandom, $urandom}, '0);
    send_plane(2, 1'b1, COLS, 1, {$urandom, $urandom, $urandom}, '0);
    for (int p = 0; p < PLANES; p++) send_plane(7, 1'b1, COLS, 1, {$urandom, $urandom, $urandom}, '1);
    check("mis_addr", bus.row_addr, 7);
    for (int p = 0; p < PLANES; p++)
      send_plane(9, p != 2, COLS, p == 0 ? 3 : 1, {$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom});
    for (int p = 0; p < 3; p++) send_plane(4, 1'b1, COLS, 1, '1, '1);
    shift(0, 0);
    do_reset();
    for (int p = 0; p < PLANES; p++) send_plane(6, 1'b1, COLS, 1, {$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom});
    shift(0, 0);
    shift(0, 0);
`ifdef HUB75_ROW_CAPTURE_STATS_EN
    check("post_rst_row_cnt", bus.row_cnt, 1);
    check("post_rst_err_cnt", bus.err_cnt, 0);
`endif
    ra = ADDR_W'($urandom);
    for (int k = 0; k < 48; k++) begin
      if (m_pidx == 0 || $urandom_range(0, 9) == 0) ra = ADDR_W'($urandom);
      n = $urandom_range(0, 9) == 0 ? $urandom_range(COLS - 2, COLS + 2) : COLS;
      send_plane(ra, $urandom_range(0, 9) != 0, n, $urandom_range(1, 3),
                 {$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom});
    end
    repeat (4) shift(0, 0);
    check("rows_drained", exp_rows.size(), 0);
    check("errs_drained", exp_errs.size(), 0);
`ifdef HUB75_ROW_CAPTURE_STATS_EN
    check("row_cnt", bus.row_cnt, 16'(m_rows));
    check("err_cnt", bus.err_cnt, 16'(m_errs));
`else
    check("row_cnt_off", bus.row_cnt, 0);
    check("err_cnt_off", bus.err_cnt, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
